// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared literal, freelitcnt, result and sequencer state encodings
package sat_pkg;

    typedef enum logic [1:0] {
        LIT_FREE  = 2'd0,
        LIT_FALSE = 2'd1,
        LIT_TRUE  = 2'd2,
        LIT_CONFL = 2'd3
    } lit_val_e;

    // Thermometer-style tail of the freelitcnt chain; 2'b10 never appears legally.
    localparam logic [1:0] FLC_NONE = 2'b00;
    localparam logic [1:0] FLC_ONE  = 2'b01;
    localparam logic [1:0] FLC_MANY = 2'b11;

    typedef enum logic [1:0] {
        RES_UNRES    = 2'd0,
        RES_SAT      = 2'd1,
        RES_UNIT     = 2'd2,
        RES_CONFLICT = 2'd3
    } res_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PAD    = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_EVAL   = 3'd5,
        ST_REPORT = 3'd6
    } state_e;

endpackage

// File: rtl/clause_row_classify.sv
// rtl/clause_row_classify.sv - combinational clause classification from row summary signals
module clause_row_classify
    import sat_pkg::*;
(
    input  logic       clausesat_i,
    input  logic [1:0] freelitcnt_i,
    output res_e       result_o
);

    always_comb begin
        result_o = RES_UNRES;
        if (clausesat_i) begin
            result_o = RES_SAT;
        end else if (freelitcnt_i == FLC_NONE) begin
            result_o = RES_CONFLICT;
        end else if (freelitcnt_i == FLC_ONE) begin
            result_o = RES_UNIT;
        end
    end

endmodule

// File: rtl/clause_row_ctrl.sv
// rtl/clause_row_ctrl.sv - load/pad/clear/evaluate sequencer for one clause row
// Optional UNIT/CONFLICT statistics counters when CLAUSE_ROW_STATS_EN is defined.
module clause_row_ctrl
    import sat_pkg::*;
#(
    parameter int NUM_LIT    = 8,
    parameter int IDX_W      = $clog2(NUM_LIT),
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               eval_i,
    input  logic               lit_valid_i,
    input  logic [1:0]         lit_value_i,
    input  logic               lit_last_i,
    output logic               lit_ready_o,
    output logic [NUM_LIT-1:0] wr_o,
    output logic [2:0]         var_value_o,
    input  logic [1:0]         freelitcnt_i,
    input  logic               clausesat_i,
    output logic               imp_drv_o,
    output logic               cclause_drv_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         result_o
`ifdef CLAUSE_ROW_STATS_EN
    ,
    output logic [15:0]        stat_imp_o,
    output logic [15:0]        stat_conf_o
`endif
);

    localparam int              CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_LIT-1:0] wr_q;
    logic [NUM_LIT-1:0] onehot_d;
    logic [2:0]         var_q;
    logic               ready_q;
    logic               done_q;
    logic               imp_q;
    logic               cclause_q;
    res_e               res_q;
    res_e               eval_res;
    logic [1:0]         result_q;

    assign onehot_d = NUM_LIT'(1) << idx_q;

    clause_row_classify u_classify (
        .clausesat_i  (clausesat_i),
        .freelitcnt_i (freelitcnt_i),
        .result_o     (eval_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            var_q     <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            imp_q     <= 1'b0;
            cclause_q <= 1'b0;
            res_q     <= RES_UNRES;
            result_q  <= '0;
        end else begin
            wr_q      <= '0;
            var_q     <= '0;
            done_q    <= 1'b0;
            imp_q     <= 1'b0;
            cclause_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    idx_q <= '0;
                    cnt_q <= '0;
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                    end else if (start_i) begin
                        state_q <= ST_LOAD;
                        ready_q <= 1'b1;
                    end else if (eval_i) begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_LOAD: begin
                    if (lit_valid_i && ready_q) begin
                        wr_q  <= onehot_d;
                        var_q <= {lit_value_i, 1'b0};
                        if (idx_q == LAST_IDX) begin
                            ready_q <= 1'b0;
                            idx_q   <= '0;
                            state_q <= ST_SETTLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (lit_last_i) begin
                                ready_q <= 1'b0;
                                state_q <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    wr_q  <= onehot_d;
                    var_q <= {LIT_FREE, 1'b0};
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= ST_SETTLE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_CLEAR: begin
                    wr_q  <= onehot_d;
                    var_q <= {LIT_FREE, 1'b0};
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        res_q   <= RES_UNRES;
                        state_q <= ST_REPORT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_SETTLE: begin
                    // The strobe cycle of the final write does not count as settling time.
                    if (wr_q == '0) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_EVAL;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_EVAL: begin
                    res_q   <= eval_res;
                    state_q <= ST_REPORT;
                end
                ST_REPORT: begin
                    done_q    <= 1'b1;
                    result_q  <= res_q;
                    imp_q     <= (res_q == RES_UNIT);
                    cclause_q <= (res_q == RES_CONFLICT);
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLAUSE_ROW_STATS_EN
    logic [15:0] stat_imp_q;
    logic [15:0] stat_conf_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_IDLE && clear_i)) begin
            stat_imp_q  <= '0;
            stat_conf_q <= '0;
        end else if (state_q == ST_REPORT) begin
            if (res_q == RES_UNIT && stat_imp_q != 16'hFFFF) begin
                stat_imp_q <= stat_imp_q + 16'd1;
            end
            if (res_q == RES_CONFLICT && stat_conf_q != 16'hFFFF) begin
                stat_conf_q <= stat_conf_q + 16'd1;
            end
        end
    end

    assign stat_imp_o  = stat_imp_q;
    assign stat_conf_o = stat_conf_q;
`endif

    assign lit_ready_o   = ready_q;
    assign wr_o          = wr_q;
    assign var_value_o   = var_q;
    assign imp_drv_o     = imp_q;
    assign cclause_drv_o = cclause_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign result_o      = result_q;

endmodule

// File: tb/tb_clause_row_ctrl.sv
// tb/tb_clause_row_ctrl.sv - scoreboard bench for clause_row_ctrl (NUM_LIT=8, SETTLE_CYC=2)
module tb_clause_row_ctrl;

    localparam logic [1:0] R_UNRES = 2'd0;
    localparam logic [1:0] R_SAT   = 2'd1;
    localparam logic [1:0] R_UNIT  = 2'd2;
    localparam logic [1:0] R_CONF  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0, clear_i = 1'b0, eval_i = 1'b0;
    logic       lit_valid_i = 1'b0, lit_last_i = 1'b0;
    logic [1:0] lit_value_i = 2'd0;
    logic       lit_ready_o;
    logic [7:0] wr_o;
    logic [2:0] var_value_o;
    logic [1:0] freelitcnt_i = 2'b11;
    logic       clausesat_i = 1'b0;
    logic       imp_drv_o, cclause_drv_o, busy_o, done_o;
    logic [1:0] result_o;
`ifdef CLAUSE_ROW_STATS_EN
    logic [15:0] stat_imp_o, stat_conf_o;
`endif

    clause_row_ctrl #(.NUM_LIT(8), .SETTLE_CYC(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .clear_i       (clear_i),
        .eval_i        (eval_i),
        .lit_valid_i   (lit_valid_i),
        .lit_value_i   (lit_value_i),
        .lit_last_i    (lit_last_i),
        .lit_ready_o   (lit_ready_o),
        .wr_o          (wr_o),
        .var_value_o   (var_value_o),
        .freelitcnt_i  (freelitcnt_i),
        .clausesat_i   (clausesat_i),
        .imp_drv_o     (imp_drv_o),
        .cclause_drv_o (cclause_drv_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o)
`ifdef CLAUSE_ROW_STATS_EN
        ,
        .stat_imp_o    (stat_imp_o),
        .stat_conf_o   (stat_conf_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] wr;
        logic [1:0] val;
    } wr_t;

    typedef struct {
        int         at_cyc;
        logic [1:0] res;
        logic       imp;
        logic       cc;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_o != 8'd0) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", {24'd0, wr_o}, 32'd0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_strobe", {24'd0, wr_o}, {24'd0, w.wr});
                chk("wr_value", {29'd0, var_value_o}, {29'd0, w.val, 1'b0});
            end
        end else begin
            chk("var_idle", {29'd0, var_value_o}, 32'd0);
        end
        if (done_o) begin
            if (rq.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = rq.pop_front();
                chk("done_cyc", cyc, r.at_cyc);
                chk("result", {30'd0, result_o}, {30'd0, r.res});
                chk("imp_drv", {31'd0, imp_drv_o}, {31'd0, r.imp});
                chk("cclause_drv", {31'd0, cclause_drv_o}, {31'd0, r.cc});
            end
        end else if (imp_drv_o || cclause_drv_o) begin
            chk("drv_without_done", {30'd0, imp_drv_o, cclause_drv_o}, 32'd0);
        end
    end

    // Returns at the negedge after the command edge; c0 is that edge's number.
    task automatic cmd(input logic c, input logic s, input logic e, output int c0);
        @(negedge clk);
        clear_i = c; start_i = s; eval_i = e;
        c0 = cyc + 1;
        @(negedge clk);
        clear_i = 1'b0; start_i = 1'b0; eval_i = 1'b0;
    endtask

    task automatic send(input logic [1:0] v, input logic last, input int idx, output int hs);
        int t = 0;
        lit_valid_i = 1'b1; lit_value_i = v; lit_last_i = last;
        while (!lit_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!lit_ready_o) chk("ready_timeout", 32'd0, 32'd1);
        hs = cyc + 1;
        wq.push_back('{wr: 8'd1 << idx, val: v});
        @(negedge clk);
        lit_valid_i = 1'b0; lit_last_i = 1'b0; lit_value_i = 2'd0;
    endtask

    task automatic wait_done(input int max);
        int t = 0;
        while (!done_o && t < max) begin
            @(negedge clk);
            t++;
        end
        if (!done_o) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int c0, hs, first;
        int gaps[8] = '{0, 2, 0, 1, 3, 0, 0, 1};

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, hs, first;
        int gaps[8];
        gaps = '{0, 2, 0, 1, 3, 0, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {19'd0, lit_ready_o, wr_o, var_value_o, busy_o, done_o},
            32'd0);
        chk("rst_drv_result", {28'd0, imp_drv_o, cclause_drv_o, result_o}, 32'd0);
        rst = 1'b0;

        // Full load: seven FALSE then TRUE, satisfied
        clausesat_i = 1'b1; freelitcnt_i = 2'b11;
        cmd(1'b0, 1'b1, 1'b0, c0);
        for (int i = 0; i < 8; i++) begin
            send((i == 7) ? 2'd2 : 2'd1, i == 7, i, hs);
            if (i == 0) begin
                first = hs;
                rq.push_back('{at_cyc: first + 12, res: R_SAT, imp: 1'b0, cc: 1'b0});
            end
        end
        chk("ready_after_full", {31'd0, lit_ready_o}, 32'd0);
        wait_done(30);

        // Short clause 1,1,0 padded to cells 3..7, unit
        clausesat_i = 1'b0; freelitcnt_i = 2'b01;
        cmd(1'b0, 1'b1, 1'b0, c0);
        send(2'd1, 1'b0, 0, first);
        send(2'd1, 1'b0, 1, hs);
        send(2'd0, 1'b1, 2, hs);
        for (int i = 3; i < 8; i++) wq.push_back('{wr: 8'd1 << i, val: 2'd0});
        rq.push_back('{at_cyc: first + 12, res: R_UNIT, imp: 1'b1, cc: 1'b0});
        chk("ready_after_last", {31'd0, lit_ready_o}, 32'd0);
        wait_done(30);

        // Re-evaluation: conflict then unresolved
        freelitcnt_i = 2'b00;
        cmd(1'b0, 1'b0, 1'b1, c0);
        rq.push_back('{at_cyc: c0 + 4, res: R_CONF, imp: 1'b0, cc: 1'b1});
        chk("busy_in_eval", {31'd0, busy_o}, 32'd1);
        wait_done(20);
        freelitcnt_i = 2'b11;
        cmd(1'b0, 1'b0, 1'b1, c0);
        rq.push_back('{at_cyc: c0 + 4, res: R_UNRES, imp: 1'b0, cc: 1'b0});
        wait_done(20);
`ifdef CLAUSE_ROW_STATS_EN
        chk("stat_imp_pre_clear", {16'd0, stat_imp_o}, 32'd1);
        chk("stat_conf_pre_clear", {16'd0, stat_conf_o}, 32'd1);
`endif

        // All commands together: clear wins, start during clear ignored
        cmd(1'b1, 1'b1, 1'b1, c0);
        for (int i = 0; i < 8; i++) wq.push_back('{wr: 8'd1 << i, val: 2'd0});
        rq.push_back('{at_cyc: c0 + 9, res: R_UNRES, imp: 1'b0, cc: 1'b0});
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("ready_in_clear", {31'd0, lit_ready_o}, 32'd0);
        wait_done(30);
        repeat (3) @(negedge clk);
        chk("idle_after_clear", {30'd0, busy_o, lit_ready_o}, 32'd0);
`ifdef CLAUSE_ROW_STATS_EN
        chk("stat_imp_cleared", {16'd0, stat_imp_o}, 32'd0);
        chk("stat_conf_cleared", {16'd0, stat_conf_o}, 32'd0);
`endif

        // Gapped literal stream, unit
        clausesat_i = 1'b0; freelitcnt_i = 2'b01;
        cmd(1'b0, 1'b1, 1'b0, c0);
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) @(negedge clk);
            send((i % 2 == 1) ? 2'd2 : 2'd1, i == 7, i, hs);
        end
        rq.push_back('{at_cyc: hs + 5, res: R_UNIT, imp: 1'b1, cc: 1'b0});
        wait_done(30);
`ifdef CLAUSE_ROW_STATS_EN
        chk("stat_imp_one", {16'd0, stat_imp_o}, 32'd1);
        chk("stat_conf_zero", {16'd0, stat_conf_o}, 32'd0);
`endif

        // Reset after three literals
        cmd(1'b0, 1'b1, 1'b0, c0);
        send(2'd1, 1'b0, 0, hs);
        send(2'd2, 1'b0, 1, hs);
        send(2'd1, 1'b0, 2, hs);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr", {24'd0, wr_o}, 32'd0);
        chk("rst_mid_busy_ready", {30'd0, busy_o, lit_ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy_o, lit_ready_o}, 32'd0);
`ifdef CLAUSE_ROW_STATS_EN
        chk("stat_imp_rst", {16'd0, stat_imp_o}, 32'd0);
`endif

        chk("wq_drained", wq.size(), 32'd0);
        chk("rq_drained", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clause_row_ctrl.md
Name: clause_row_ctrl

Overview:
Sequencer for one clause row of NUM_LIT lit_cell instances.
- Loads a clause's literal values into the cells one per cycle via one-hot write strobes and pads unused cells with free.
- Evaluates the row through the freelitcnt chain output and the OR-ed clausesat, then classifies the clause as SAT, UNIT, CONFLICT or UNRESOLVED.
- On UNIT or CONFLICT, pulses the row's imp_drv or cclause_drv inputs.

Parameters:
NUM_LIT, 8, number of lit_cells in the row (≥2)
IDX_W, $clog2(NUM_LIT), literal index width
SETTLE_CYC, 2, wait cycles after the last write or eval request before sampling (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  begin loading a new clause (IDLE only)
clear_i  in  1  write free to all cells (IDLE only)
eval_i  in  1  re-evaluate the row without reloading (IDLE only)
lit_valid_i  in  1  literal value offered
lit_value_i  in  2  0 free, 1 false, 2 true, 3 conflict
lit_last_i  in  1  offered literal is the clause's last
lit_ready_o  out  1  literal accepted when valid&ready
wr_o  out  NUM_LIT  one-hot write strobe to lit_cell wr_i
var_value_o  out  3  to var_value_frombase_i; [2:1]=value, [0]=0
freelitcnt_i  in  2  chain tail: 00 none free, 01 one, 11 two or more
clausesat_i  in  1  OR of cell clausesat_o
imp_drv_o  out  1  one-cycle pulse to cell imp_drv_i
cclause_drv_o  out  1  one-cycle pulse to cell cclause_drv_i
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle result strobe
result_o  out  2  0 UNRES, 1 SAT, 2 UNIT, 3 CONFLICT; held until next done_o

Behaviour:
- Reset: state IDLE, idx=0. All outputs 0, including wr_o, var_value_o, result_o and lit_ready_o.
- Reset mid-operation aborts at the next edge. No partial write strobe is issued after reset.
- States: IDLE, LOAD, PAD, CLEAR, SETTLE, EVAL, REPORT.
- IDLE command priority when asserted together: clear_i > start_i > eval_i.
  - clear_i → CLEAR.
  - start_i → LOAD with idx=0.
  - eval_i → SETTLE.
  - Commands in any other state are ignored and not queued.
- LOAD:
  - lit_ready_o=1.
  - On handshake in cycle t: in cycle t+1, wr_o=1<<idx and var_value_o[2:1]=lit_value_i. Then idx++.
  - If lit_last_i, or idx==NUM_LIT-1 at acceptance: go to PAD if cells remain, else SETTLE.
  - Literals beyond NUM_LIT are never accepted; ready drops after the final acceptance.
  - Idle cycles with valid=0 are allowed and drive wr_o=0.
- PAD: one cell per cycle, wr_o=1<<idx with value 0, until idx wraps past NUM_LIT-1 → SETTLE.
- CLEAR: writes value 0 to cells 0..NUM_LIT-1, one per cycle (NUM_LIT cycles) → REPORT with done_o, result_o=UNRES.
- var_value_o returns to 0 in every cycle where wr_o=0.
- SETTLE: counts SETTLE_CYC cycles with wr_o=0 → EVAL.
- EVAL: samples inputs for one cycle. Priority:
  - clausesat_i → SAT;
  - freelitcnt_i==00 → CONFLICT;
  - freelitcnt_i==01 → UNIT;
  - else UNRES.
  - freelitcnt_i==10 is illegal; treat it as UNRES.
- REPORT: one cycle.
  - done_o=1, result_o updated.
  - imp_drv_o=1 iff UNIT; cclause_drv_o=1 iff CONFLICT.
  - → IDLE.
- Latencies:
  - Full load of N literals at one per cycle: done_o arrives N+SETTLE_CYC+2 cycles after the first handshake.
  - eval_i: done_o arrives SETTLE_CYC+2 cycles after the IDLE command edge.
- idx width is IDX_W; wrap is detected by compare, not overflow.

Optional Feature:
CLAUSE_ROW_STATS_EN
- Defined: adds outputs stat_imp_o[15:0] and stat_conf_o[15:0].
  - They count REPORT cycles with UNIT and CONFLICT respectively.
  - Counters saturate at 16'hFFFF and are cleared by rst and by clear_i accepted in IDLE.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sat_pkg:
  - lit value enum (FREE=0, FALSE=1, TRUE=2, CONFL=3);
  - freelitcnt encodings;
  - result enum (RES_UNRES, RES_SAT, RES_UNIT, RES_CONFLICT);
  - the state enum.
- One natural sub-module, clause_row_classify: the combinational EVAL priority decode (clausesat, freelitcnt → result). Everything else stays in a single FSM.

Test Plan:
- Reset: assert rst 2 cycles mid-LOAD (after 3 literals) → next cycle wr_o=0, busy_o=0, lit_ready_o=0; no further strobes.
- Full load, NUM_LIT=8: values 1,1,1,1,1,1,1,2 back-to-back → wr_o walks 0x01..0x80 with matching var_value_o[2:1]; model returns clausesat=1 → done_o at cycle 8+2+2=12 after the first handshake, result_o=SAT, no drv pulse.
- Short clause: 3 literals 1,1,0 with last on the third → PAD writes cells 3..7 with value 0; freelitcnt_i=01, clausesat=0 → result UNIT, imp_drv_o pulse coincident with done_o.
- Conflict via eval_i: from IDLE pulse eval_i with freelitcnt_i=00, clausesat=0 → done_o 4 cycles later, result CONFLICT, cclause_drv_o pulse; re-eval with freelitcnt_i=11 → UNRES.
- Simultaneous commands: clear_i+start_i+eval_i in IDLE → CLEAR wins; wr_o 0x01..0x80 with value 0, then done_o with UNRES; start_i pulsed during CLEAR is ignored.
- Backpressure: lit_valid_i gapped (1,0,0,1,…) → no wr_o in gap cycles; idx advances only on handshakes; with CLAUSE_ROW_STATS_EN, stat_imp_o increments exactly once per UNIT.
